// File: rtl/div_issue_ctrl_q4_4_if.sv
// Handshake bundle for div_issue_ctrl_q4_4: upstream operand stream, downstream
// result stream, divider start/valid port and status outputs.
interface div_issue_ctrl_q4_4_if;
  // Upstream operand stream
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_num;
  logic [7:0] in_den;
  // Downstream result stream
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_quot;
  logic       out_err;
  logic       out_timeout;
  // Divider port
  logic       div_start;
  logic [7:0] div_numerator;
  logic [7:0] div_denominator;
  logic [7:0] div_quotient;
  logic       div_valid;
  logic       div_error;
  // Status
  logic       busy;
  logic [7:0] done_count;
  logic [7:0] err_count;

  // Environment side: producer, consumer and divider
  modport master (
    output in_valid, in_num, in_den, out_ready, div_quotient, div_valid, div_error,
    input  in_ready, out_valid, out_quot, out_err, out_timeout,
           div_start, div_numerator, div_denominator, busy, done_count, err_count
  );

  // Controller side
  modport slave (
    input  in_valid, in_num, in_den, out_ready, div_quotient, div_valid, div_error,
    output in_ready, out_valid, out_quot, out_err, out_timeout,
           div_start, div_numerator, div_denominator, busy, done_count, err_count
  );
endinterface

// File: rtl/div_issue_ctrl_q4_4.sv
// Request-side controller for the signed Q4.4 Goldschmidt divider: buffers operand
// pairs in a FIFO, issues one at a time, returns quotient/error/timeout downstream.
module div_issue_ctrl_q4_4 #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  div_issue_ctrl_q4_4_if.slave bus
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StFlush} state_e;

  state_e state_q, state_d;

  // Operand FIFO, {num, den} per entry; pointers carry an extra wrap bit
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            fifo_empty, fifo_full, push, pop;
  logic [15:0]     fifo_head;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_q, start_d;
  logic [7:0]      num_q, num_d, den_q, den_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      quot_q, quot_d;
  logic            err_q, err_d;
  logic            tout_q, tout_d;
  logic [7:0]      done_cnt_q, done_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[AddrW-1:0]];
  assign push       = bus.in_valid && !fifo_full;
  assign pop        = (state_q == StIssue);
  assign wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

  // FIFO storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= {bus.in_num, bus.in_den};
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      num_q       <= '0;
      den_q       <= '0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      err_q       <= 1'b0;
      tout_q      <= 1'b0;
      done_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      num_q       <= num_d;
      den_q       <= den_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      err_q       <= err_d;
      tout_q      <= tout_d;
      done_cnt_q  <= done_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state logic; div_valid beats timeout expiry in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (bus.div_valid || cnt_q == CntLast) state_d = StResp;
      StResp:  if (bus.out_ready) state_d = tout_q ? StFlush : StIdle;
      StFlush: if (bus.div_valid || cnt_q == CntLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output/datapath next values. Start and operands are registered off state_d so
  // they appear in the ISSUE cycle; the head entry seen in IDLE is the one popped.
  always_comb begin
    cnt_d       = '0;
    start_d     = (state_d == StIssue);
    num_d       = num_q;
    den_d       = den_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    err_d       = err_q;
    tout_d      = tout_q;
    done_cnt_d  = done_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (start_d) begin
      num_d = fifo_head[15:8];
      den_d = fifo_head[7:0];
    end
    unique case (state_q)
      StIdle, StIssue: cnt_d = '0;
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus.div_valid) begin
          out_valid_d = 1'b1;
          quot_d      = bus.div_quotient;
          err_d       = bus.div_error;
          tout_d      = 1'b0;
        end else if (cnt_q == CntLast) begin
          out_valid_d = 1'b1;
          quot_d      = 8'h00;
          err_d       = 1'b1;
          tout_d      = 1'b1;
        end
      end
      StResp: begin
        cnt_d = '0;
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 8'd1;
          err_cnt_d   = err_cnt_q + {7'd0, err_q};
        end
      end
      StFlush: cnt_d = cnt_q + CntW'(1);
      default: cnt_d = '0;
    endcase
  end

  assign bus.in_ready        = !fifo_full;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_quot        = quot_q;
  assign bus.out_err         = err_q;
  assign bus.out_timeout     = tout_q;
  assign bus.div_start       = start_q;
  assign bus.div_numerator   = num_q;
  assign bus.div_denominator = den_q;
  assign bus.busy            = (state_q != StIdle) || !fifo_empty;
  assign bus.done_count      = done_cnt_q;
  assign bus.err_count       = err_cnt_q;

endmodule

// File: tb/tb_div_issue_ctrl_q4_4.sv
// Scoreboard bench for div_issue_ctrl_q4_4 with a behavioural Q4.4 divider model.
module tb_div_issue_ctrl_q4_4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  div_issue_ctrl_q4_4_if dif ();

  div_issue_ctrl_q4_4 #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected entries: {quot[7:0], err, timeout}
  logic [9:0] sb_q [$];
  logic [7:0] exp_done = 8'd0;
  logic [7:0] exp_err  = 8'd0;

  // Divider model controls
  int         div_lat   = 3;
  int         busy_cnt  = 0;
  bit         mute      = 1'b0;
  bit         stray_req = 1'b0;
  logic [9:0] pend_res;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Truncating signed Q4.4 divide with saturation; zero divisor flags an error
  function automatic logic [9:0] div_model(input logic [7:0] n, input logic [7:0] d);
    int ni;
    int di;
    int q;
    if (d == 8'h00) return {8'h00, 1'b1, 1'b0};
    ni = $signed(n);
    di = $signed(d);
    q  = (ni * 16) / di;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return {q[7:0], 1'b0, 1'b0};
  endfunction

  // Divider model: responds div_lat cycles after a start, or emits a requested stray pulse
  initial begin
    dif.div_valid    = 1'b0;
    dif.div_quotient = 8'h00;
    dif.div_error    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dif.div_valid = 1'b0;
      if (!rst_n) begin
        busy_cnt = 0;
      end else if (stray_req) begin
        stray_req        = 1'b0;
        dif.div_valid    = 1'b1;
        dif.div_quotient = 8'h7F;
        dif.div_error    = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          dif.div_valid    = 1'b1;
          dif.div_quotient = pend_res[9:2];
          dif.div_error    = pend_res[1];
        end
      end else if (dif.div_start && !mute) begin
        pend_res = div_model(dif.div_numerator, dif.div_denominator);
        busy_cnt = div_lat;
      end
    end
  end

  // Output monitor: scoreboard pop on accept, stability while stalled
  logic       stalled = 1'b0;
  logic [9:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check_eq("stall_valid", dif.out_valid, 1'b1);
        check_eq("stall_data", {dif.out_quot, dif.out_err, dif.out_timeout}, held);
      end
      if (dif.out_valid && dif.out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_out", dif.out_valid, 1'b0);
        end else begin
          logic [9:0] e;
          e = sb_q.pop_front();
          check_eq("result", {dif.out_quot, dif.out_err, dif.out_timeout}, e);
          exp_done = exp_done + 8'd1;
          if (e[1]) exp_err = exp_err + 8'd1;
        end
      end
      stalled = dif.out_valid && !dif.out_ready;
      held    = {dif.out_quot, dif.out_err, dif.out_timeout};
    end
  end

  task automatic push(input logic [7:0] n, input logic [7:0] d, input bit exp_timeout);
    int w;
    w = 0;
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.in_num   = n;
    dif.in_den   = d;
    while (!dif.in_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!dif.in_ready) begin
      check_eq("push_wait", dif.in_ready, 1'b1);
    end else begin
      sb_q.push_back(exp_timeout ? {8'h00, 1'b1, 1'b1} : div_model(n, d));
    end
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int w;
    w = 0;
    while ((sb_q.size() != 0 || dif.out_valid) && w < max_cycles) begin
      @(posedge clk);
      w++;
    end
    check_eq("drain", sb_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_done"}, dif.done_count, exp_done);
    check_eq({tag, "_err"}, dif.err_count, exp_err);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_outs"}, {dif.div_start, dif.div_numerator, dif.div_denominator,
                              dif.out_valid, dif.out_quot, dif.out_err, dif.out_timeout}, 0);
    check_eq({tag, "_stat"}, {dif.busy, dif.done_count, dif.err_count}, 0);
    check_eq({tag, "_in_ready"}, dif.in_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    dif.in_valid  = 1'b0;
    dif.in_num    = 8'h00;
    dif.in_den    = 8'h00;
    dif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_reset_state("reset");

    // Single op with issue and result latency
    push(8'h30, 8'h10, 1'b0);
    check_eq("issue_n1", dif.div_start, 1'b0);
    @(posedge clk);
    #1;
    check_eq("issue_n2", dif.div_start, 1'b1);
    check_eq("issue_ops", {dif.div_numerator, dif.div_denominator}, 16'h3010);
    n = 0;
    while (!dif.div_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("div_valid_seen", dif.div_valid, 1'b1);
    @(posedge clk);
    #1;
    check_eq("result_latency", dif.out_valid, 1'b1);
    wait_drain(200);
    check_counts("single");
    check_eq("single_done_abs", dif.done_count, 8'd1);
    check_eq("operand_hold", {dif.div_numerator, dif.div_denominator}, 16'h3010);

    // Divide by zero
    push(8'h10, 8'h00, 1'b0);
    wait_drain(200);
    check_counts("divzero");
    check_eq("divzero_err_abs", dif.err_count, 8'd1);

    // Signed pass-through, then stray pulse in IDLE
    push(8'hE0, 8'h10, 1'b0);
    wait_drain(200);
    @(negedge clk);
    stray_req = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("stray_idle_valid", dif.out_valid, 1'b0);
    check_eq("stray_idle_busy", dif.busy, 1'b0);
    check_counts("stray");

    // Full FIFO with back-pressure
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    div_lat = 2;
    for (int i = 0; i < 5; i++) begin
      push(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b0);
    end
    @(negedge clk);
    check_eq("full_in_ready", dif.in_ready, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("full_stalled_ready", dif.in_ready, 1'b0);
    check_eq("full_stalled_valid", dif.out_valid, 1'b1);
    @(posedge clk);
    #1;
    dif.out_ready = 1'b1;
    push(8'h48, 8'hF0, 1'b0);
    wait_drain(500);
    check_counts("full");

    // Timeout, stale pulse in FLUSH, then a normal op
    mute = 1'b1;
    push(8'h11, 8'h22, 1'b1);
    n = 0;
    while (!dif.div_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_start_seen", dif.div_start, 1'b1);
    n = 0;
    while (!dif.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_latency", n, 65);
    wait_drain(50);
    check_eq("to_flush_busy", dif.busy, 1'b1);
    @(negedge clk);
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("flush_exit", dif.busy, 1'b0);
    mute = 1'b0;
    push(8'h20, 8'h10, 1'b0);
    wait_drain(200);
    check_counts("timeout");

    // Reset while WAITing with two FIFO entries
    div_lat = 20;
    push(8'h01, 8'h02, 1'b0);
    push(8'h03, 8'h04, 1'b0);
    push(8'h05, 8'h06, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    sb_q.delete();
    exp_done = 8'd0;
    exp_err  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("post_reset_busy", dif.busy, 1'b0);
    div_lat = 2;
    push(8'h40, 8'h20, 1'b0);
    wait_drain(200);
    check_counts("post_reset");
    check_eq("post_reset_done_abs", dif.done_count, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl_q4_4.md
# div_issue_ctrl_q4_4

Request-side controller for the signed Q4.4 Goldschmidt divider. It accepts operand pairs from an upstream valid/ready stream and buffers them in a small FIFO. It issues them one at a time to the divider's start/valid/error port and returns each quotient, with error and timeout flags, on a downstream valid/ready stream. It sits between the datapath sequencer and the divider, and owns all handshake timing toward the divider.

## Interface
- `FIFO_DEPTH`, default 4: operand FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, default 64: maximum cycles from `div_start` to `div_valid` before a timeout is declared; ≥2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream operand pair valid.
- `in_ready` output 1: FIFO not full.
- `in_num` input 8: signed Q4.4 numerator.
- `in_den` input 8: signed Q4.4 denominator.
- `out_valid` output 1: result valid; held until accepted.
- `out_ready` input 1: downstream accept.
- `out_quot` output 8: signed Q4.4 quotient.
- `out_err` output 1: divider reported error (divide by zero), or timeout.
- `out_timeout` output 1: result produced by timeout, not by the divider.
- `div_start` output 1: one-cycle start pulse to the divider.
- `div_numerator` output 8: operand to the divider.
- `div_denominator` output 8: operand to the divider.
- `div_quotient` input 8: divider result.
- `div_valid` input 1: divider one-cycle completion pulse.
- `div_error` input 1: divider error; qualified by `div_valid`.
- `busy` output 1: state ≠ IDLE, or FIFO non-empty.
- `done_count` output 8: completed responses; wraps at 255→0.
- `err_count` output 8: responses with `out_err`=1; wraps.

## Operation
- **FIFO**
  - Push on `in_valid && in_ready`; `in_ready` = !full, combinational from registered pointers.
  - Pop only in ISSUE. No bypass: a pushed entry is visible the cycle after the push.
  - Push while full is impossible (`in_ready`=0). Push and pop in the same cycle are both performed; occupancy is unchanged.
- **FSM states**
  - IDLE: if FIFO non-empty → ISSUE.
  - ISSUE: `div_start`=1 for exactly this cycle; `div_numerator`/`div_denominator` = FIFO head; pop; reset timeout counter; → WAIT.
  - WAIT:
    - On `div_valid`: capture `div_quotient` and `div_error` into the output registers; `out_timeout`=0; → RESP.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES−1: capture quotient=0x00, err=1, timeout=1; → RESP.
  - RESP: `out_valid`=1. On `out_ready`: increment `done_count`, increment `err_count` if `out_err`; then → FLUSH if the response was a timeout, else → IDLE.
  - FLUSH: wait up to TIMEOUT_CYCLES for a stale `div_valid` and discard it. Go → IDLE on the stale pulse or on expiry.
- **Operand hold:** `div_numerator`/`div_denominator` are registered and hold the last issued pair until the next ISSUE.
- **Stray pulses:** `div_valid` outside WAIT and FLUSH is ignored and never produces a response.
- **Data path:** no arithmetic on data; the quotient passes through unmodified. Counters are 8-bit modulo.

## Timing
- **Reset values:** all registered outputs 0 (`div_start`, operands, `out_valid`, `out_quot`, `out_err`, `out_timeout`, both counters, `busy`); FIFO empty; state IDLE.
  - `in_ready`=1 once `rst_n` is high.
- **Reset mid-operation** (any state): immediately return to IDLE and empty the FIFO; the pending response is lost; counters clear.
- **Issue latency:** push accepted at edge N → `div_start`=1 in cycle N+2 (IDLE at N+1, ISSUE at N+2).
- **Next-issue spacing:** the next `div_start` comes no sooner than 2 cycles after the current response is accepted (RESP→IDLE→ISSUE). This guarantees the divider is back in IDLE.
- **Result latency:** `div_valid` sampled at edge M → `out_valid`=1 from cycle M+1.
- **Ordering:** results are returned strictly in FIFO order; at most one operation is outstanding.
- **Back-pressure:** `out_valid`, `out_quot`, `out_err` and `out_timeout` are stable while `out_ready`=0. The FIFO keeps accepting input until full.
- **`div_valid` and timeout expiry in the same cycle:** `div_valid` wins; no timeout.

## Test plan
- Single op: push 0x30/0x10, divider model returns 0x30 with 0 err → `div_start` at N+2; `out_quot`=0x30, `out_err`=0, `out_timeout`=0; `done_count`=1.
- Divide by zero: push 0x10/0x00, divider returns `div_error`=1 with quotient 0x00 → `out_err`=1, `out_timeout`=0, `out_quot`=0x00; `err_count`=1.
- Full and back-pressure: hold `out_ready`=0 and push 6 pairs with DEPTH=4 → `in_ready` falls after 4 FIFO entries plus 1 in flight. Release `out_ready` → 5 results in order, outputs stable while stalled; the 6th pair is accepted once space frees.
- Timeout: divider model never pulses `div_valid` → after 64 cycles of WAIT, result 0x00 with `out_err`=1 and `out_timeout`=1. A late stale `div_valid` during FLUSH is discarded; the next operation completes normally.
- Signed pass-through: push 0xE0/0x10, divider returns 0xE0 → `out_quot`=0xE0. Also a stray `div_valid` while in IDLE produces no `out_valid`.
- Reset in WAIT: assert `rst_n`=0 mid-operation with 2 FIFO entries → all outputs 0, `busy`=0, counters 0. After release, a new push completes normally.
